// File: rtl/alfsr_pkg.sv
// Shared types, default constants and the LFSR step function for the
// alternating-step generator (alfsr_gen).
package alfsr_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    WARM = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int W0_DEF = 11;
  localparam int W1_DEF = 13;
  localparam int W2_DEF = 17;
  localparam int SW_DEF = W0_DEF + W1_DEF + W2_DEF;

  localparam logic [W0_DEF-1:0] TAP0_DEF = 11'h500;    // x^11+x^9+1
  localparam logic [W1_DEF-1:0] TAP1_DEF = 13'h100D;   // x^13+x^4+x^3+x+1
  localparam logic [W2_DEF-1:0] TAP2_DEF = 17'h12000;  // x^17+x^14+1
  localparam logic [SW_DEF-1:0] SEED_DEF = 41'h1_5A5A_C3C3_1;

  // One Fibonacci step of a w-bit register r with feedback mask t; the value
  // is carried in a 64-bit container so every register width shares one helper.
  function automatic logic [63:0] lfsr_next(input logic [63:0] r,
                                            input logic [63:0] t,
                                            input int          w);
    logic [63:0] mask;
    logic        fb;
    mask = (64'd1 << w) - 64'd1;
    fb   = ^(r & t & mask);
    return ((r << 1) | {63'd0, fb}) & mask;
  endfunction

endpackage

// File: rtl/alfsr_gen_if.sv
// Bus between the alfsr_gen bit source (slave) and whoever drives its
// step/seed controls (master); also carries the FSM state for observation.
interface alfsr_gen_if #(
  parameter int SW = alfsr_pkg::SW_DEF
);
  // RND_valid is a one-cycle strobe with no ready: a bit is delivered on every
  // cycle RND_valid is high and the consumer must take it; the only way to
  // throttle the source is to drop en.
  logic                 en;
  logic                 seed_load;
  logic [SW-1:0]        seed_in;
  logic                 RND_out;
  logic                 RND_valid;
  logic                 warming;
  alfsr_pkg::state_t    dbg_state;

  modport master (
    output en, seed_load, seed_in,
    input  RND_out, RND_valid, warming, dbg_state
  );

  modport slave (
    input  en, seed_load, seed_in,
    output RND_out, RND_valid, warming, dbg_state
  );

endinterface

// File: rtl/alfsr_gen_lfsr_core.sv
// lfsr_core: one Fibonacci LFSR register with seed load and a zero-seed guard
// (an all-zero load becomes 1 so the register can never lock up).
module lfsr_core
  import alfsr_pkg::*;
#(
  parameter int           W = W0_DEF,
  parameter logic [W-1:0] T = TAP0_DEF
) (
  input  logic         clk,
  input  logic         rst_load,
  input  logic [W-1:0] load_val,
  input  logic         step,
  output logic [W-1:0] q
);

  logic [63:0]   nx_wide;
  logic [63:W]   unused_hi;

  assign nx_wide   = lfsr_next(64'(q), 64'(T), W);
  assign unused_hi = nx_wide[63:W];

  always_ff @(posedge clk) begin
    if (rst_load) begin
      q <= (load_val == '0) ? W'(1) : load_val;
    end else if (step) begin
      q <= nx_wide[W-1:0];
    end
  end

endmodule

// File: rtl/alfsr_gen.sv
// alfsr_gen: alternating-step LFSR random bit source. R0 picks whether R1 or
// R2 advances; the output is the XOR of their MSBs. Define ALFSR_WARMUP_EN to
// build the warm-up discard phase (WARM state, counter, live warming output).
module alfsr_gen
  import alfsr_pkg::*;
#(
  parameter int                    W0     = W0_DEF,
  parameter int                    W1     = W1_DEF,
  parameter int                    W2     = W2_DEF,
  parameter logic [W0-1:0]         TAP0   = TAP0_DEF,
  parameter logic [W1-1:0]         TAP1   = TAP1_DEF,
  parameter logic [W2-1:0]         TAP2   = TAP2_DEF,
  parameter logic [W0+W1+W2-1:0]   SEED   = SEED_DEF,
  parameter int                    WARMUP = 64
) (
  input  logic       clk,
  input  logic       rst,
  alfsr_gen_if.slave bus
);

  localparam int SW = W0 + W1 + W2;

  state_t          state;
  logic [SW-1:0]   seed_q;
  logic [W0-1:0]   r0_q;
  logic [W1-1:0]   r1_q;
  logic [W2-1:0]   r2_q;
  logic            rnd_out_q;
  logic            rnd_valid_q;
  logic            load_now;
  logic            stepping;
  logic            sel1;
  logic            nx_bit;

`ifdef ALFSR_WARMUP_EN
  localparam int CW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  logic [CW-1:0] warm_cnt;
  logic          warming_q;
`else
  logic [31:0]   unused_warmup;
  assign unused_warmup = WARMUP;
`endif

  assign load_now = (state == LOAD);
  assign stepping = !rst && !bus.seed_load && bus.en && (state == WARM || state == RUN);

  // R0's MSB before the update selects the data register that advances; the
  // new output bit is therefore the stepped register's old second-MSB.
  assign sel1   = r0_q[W0-1];
  assign nx_bit = (sel1 ? r1_q[W1-2] : r1_q[W1-1]) ^ (sel1 ? r2_q[W2-1] : r2_q[W2-2]);

  lfsr_core #(.W(W0), .T(TAP0)) u_r0 (
    .clk      (clk),
    .rst_load (load_now),
    .load_val (seed_q[W0-1:0]),
    .step     (stepping),
    .q        (r0_q)
  );

  lfsr_core #(.W(W1), .T(TAP1)) u_r1 (
    .clk      (clk),
    .rst_load (load_now),
    .load_val (seed_q[W0+W1-1:W0]),
    .step     (stepping & sel1),
    .q        (r1_q)
  );

  lfsr_core #(.W(W2), .T(TAP2)) u_r2 (
    .clk      (clk),
    .rst_load (load_now),
    .load_val (seed_q[SW-1:W0+W1]),
    .step     (stepping & ~sel1),
    .q        (r2_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= LOAD;
      seed_q      <= SEED;
      rnd_out_q   <= 1'b0;
      rnd_valid_q <= 1'b0;
`ifdef ALFSR_WARMUP_EN
      warm_cnt    <= '0;
      warming_q   <= 1'b0;
`endif
    end else if (bus.seed_load) begin
      seed_q      <= bus.seed_in;
      state       <= LOAD;
      rnd_valid_q <= 1'b0;
`ifdef ALFSR_WARMUP_EN
      warming_q   <= 1'b0;
`endif
    end else begin
      rnd_valid_q <= 1'b0;
`ifdef ALFSR_WARMUP_EN
      warming_q   <= 1'b0;
`endif
      case (state)
        LOAD: begin
`ifdef ALFSR_WARMUP_EN
          warm_cnt <= '0;
          state    <= (WARMUP > 0) ? WARM : RUN;
`else
          state    <= RUN;
`endif
        end
`ifdef ALFSR_WARMUP_EN
        WARM: begin
          warming_q <= 1'b1;
          if (bus.en) begin
            rnd_out_q <= nx_bit;
            warm_cnt  <= warm_cnt + CW'(1);
            if (warm_cnt == CW'(WARMUP - 1)) begin
              state <= RUN;
            end
          end
        end
`endif
        RUN: begin
          if (bus.en) begin
            rnd_out_q   <= nx_bit;
            rnd_valid_q <= 1'b1;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  assign bus.RND_out   = rnd_out_q;
  assign bus.RND_valid = rnd_valid_q;
  assign bus.dbg_state = state;
`ifdef ALFSR_WARMUP_EN
  assign bus.warming   = warming_q;
`else
  assign bus.warming   = 1'b0;
`endif

endmodule

// File: tb/tb_alfsr_gen.sv
// Bench for alfsr_gen: random en/seed_load traffic against an arithmetic
// model of the alternating-step generator, with a queue-based scoreboard.
module tb_alfsr_gen;

  localparam int W0     = 11;
  localparam int W1     = 13;
  localparam int W2     = 17;
  localparam int SW     = W0 + W1 + W2;
  localparam int WARMUP = 64;
  localparam longint unsigned T0 = 64'h500;
  localparam longint unsigned T1 = 64'h100D;
  localparam longint unsigned T2 = 64'h12000;
  localparam logic [SW-1:0] SEED_VAL = 41'h1_5A5A_C3C3_1;
`ifdef ALFSR_WARMUP_EN
  localparam bit WARM_EN = 1'b1;
`else
  localparam bit WARM_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  alfsr_gen_if #(.SW(SW)) bus ();

  alfsr_gen #(.WARMUP(WARMUP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Expected per-cycle response: {stat, check_bit, bit, warming, valid}
  logic [4:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  int stat_n    = 0;
  int stat_ones = 0;

  // Model state: phase 0 = loading, 1 = discarding warm-up, 2 = producing
  int              m_phase = 0;
  longint unsigned m_r0, m_r1, m_r2;
  logic [SW-1:0]   m_seed = SEED_VAL;
  logic            m_out = 1'b0;
  int              m_warm_left = 0;
  int              m_stat_left = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic longint unsigned m_step(input longint unsigned r,
                                             input longint unsigned t, input int w);
    longint unsigned fb;
    fb = longint'($countones(r & t) % 2);
    return (r * 2 + fb) % (64'd1 << w);
  endfunction

  function automatic longint unsigned guard(input longint unsigned v);
    return (v == 0) ? 64'd1 : v;
  endfunction

  // Advance the model across one clock edge with the given inputs.
  task automatic model_edge(input logic r, input logic e, input logic sl, input logic [SW-1:0] sin);
    logic [4:0] x;
    longint unsigned c;
    x = '0;
    if (r) begin
      m_phase = 0;
      m_seed  = SEED_VAL;
      m_out   = 1'b0;
      x[3]    = 1'b1;
    end else if (sl) begin
      m_seed  = sin;
      m_phase = 0;
    end else if (m_phase == 0) begin
      m_r0 = guard(64'(m_seed[W0-1:0]));
      m_r1 = guard(64'(m_seed[W0+W1-1:W0]));
      m_r2 = guard(64'(m_seed[SW-1:W0+W1]));
      m_warm_left = WARMUP;
      m_phase = (WARM_EN && WARMUP > 0) ? 1 : 2;
    end else begin
      if (m_phase == 1) x[1] = 1'b1;
      if (e) begin
        c = (m_r0 >> (W0 - 1)) & 1;
        m_r0 = m_step(m_r0, T0, W0);
        if (c == 1) m_r1 = m_step(m_r1, T1, W1);
        else        m_r2 = m_step(m_r2, T2, W2);
        m_out = 1'(((m_r1 >> (W1 - 1)) ^ (m_r2 >> (W2 - 1))) & 1);
        if (m_phase == 2) begin
          x[0] = 1'b1;
          x[3] = 1'b1;
          if (m_stat_left > 0) begin
            x[4] = 1'b1;
            m_stat_left--;
          end
        end else begin
          m_warm_left--;
          if (m_warm_left == 0) m_phase = 2;
        end
      end
    end
    x[2] = m_out;
    exp_q.push_back(x);
  endtask

  task automatic drive(input logic r, input logic e, input logic sl, input logic [SW-1:0] sin);
    @(negedge clk);
    rst           = r;
    bus.en        = e;
    bus.seed_load = sl;
    bus.seed_in   = sin;
    model_edge(r, e, sl, sin);
  endtask

  function automatic logic [SW-1:0] rand_seed();
    logic [63:0] s;
    s = {$urandom(), $urandom()};
    if ($urandom_range(0, 3) == 0) s[W0-1:0] = '0;
    if ($urandom_range(0, 3) == 0) s[W0+W1-1:W0] = '0;
    if ($urandom_range(0, 3) == 0) s[SW-1:W0+W1] = '0;
    return s[SW-1:0];
  endfunction

  // Monitor: one expected entry per clock edge, compared just after the edge.
  initial begin
    logic [4:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rnd_valid", 32'(bus.RND_valid), 32'(e[0]));
        check("warming", 32'(bus.warming), 32'(e[1]));
        if (e[3]) check("rnd_out", 32'(bus.RND_out), 32'(e[2]));
        if (e[4]) begin
          stat_n++;
          stat_ones += int'(bus.RND_out);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [SW-1:0] s;
    rst = 1'b1;
    bus.en = 1'b0;
    bus.seed_load = 1'b0;
    bus.seed_in = '0;

    // Reset, then en held high: first valid bit latency and statistics run.
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, '0);
    m_stat_left = 4096;
    for (int i = 0; i < 4110 + WARMUP; i++) drive(1'b0, 1'b1, 1'b0, '0);
    drive(1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, 1'b0, '0);
    check("stat_bits", 32'(stat_n), 32'd4096);
    checks++;
    if (stat_ones < 1948 || stat_ones > 2148) begin
      failures++;
      $display("FAIL stat_ones: got %0d expected 1948..2148", stat_ones);
    end

    // Alternate en 1/0: valid strobes follow en, bits continue the sequence.
    for (int i = 0; i < 200; i++) drive(1'b0, 1'(i % 2 == 0), 1'b0, '0);

    // All-zero seed: every slice falls back to 1; run past one R0 period.
    drive(1'b0, 1'b1, 1'b1, '0);
    for (int i = 0; i < 2100 + WARMUP; i++) drive(1'b0, 1'b1, 1'b0, '0);

    // seed_load with en mid-run restarts the stream from the new seed.
    s = rand_seed();
    drive(1'b0, 1'b1, 1'b1, s);
    for (int i = 0; i < 60 + WARMUP; i++) drive(1'b0, 1'b1, 1'b0, '0);
    drive(1'b0, 1'b1, 1'b1, s);
    for (int i = 0; i < 60 + WARMUP; i++) drive(1'b0, 1'b1, 1'b0, '0);
    drive(1'b0, 1'b1, 1'b1, s);
    drive(1'b0, 1'b1, 1'b1, rand_seed());
    for (int i = 0; i < 40 + WARMUP; i++) drive(1'b0, 1'b1, 1'b0, '0);

    // Random traffic: sparse seed loads, en mostly high.
    for (int i = 0; i < 2500; i++)
      drive(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 39) == 0), rand_seed());

    // Reset pulsed 30 steps into a fresh start, then run again.
    drive(1'b1, 1'b1, 1'b0, '0);
    for (int i = 0; i < 31; i++) drive(1'b0, 1'b1, 1'b0, '0);
    drive(1'b1, 1'b1, 1'b0, '0);
    for (int i = 0; i < 100 + WARMUP; i++) drive(1'b0, 1'b1, 1'b0, '0);

    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, '0);
    @(posedge clk);
    #4;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alfsr_gen.md
# alfsr_gen

Alternating-step LFSR random bit generator and bitstream source for the on-chip NIST SP 800-22 test block. The stream from `RND_out` feeds that block's `RND_in` directly.

- Three Fibonacci LFSRs: a control register R0 and two data registers R1 and R2.
- Each step, R0 chooses whether R1 or R2 advances.
- The output bit is the XOR of the R1 and R2 output bits.
- The block adds seed loading, a lockup guard and an optional warm-up discard phase.

## Interface
Parameters:
- `W0`, default 11: R0 width.
- `W1`, default 13: R1 width.
- `W2`, default 17: R2 width.
- `TAP0`, default 11'h500: R0 feedback mask (x^11+x^9+1).
- `TAP1`, default 13'h100D: R1 feedback mask (x^13+x^4+x^3+x+1).
- `TAP2`, default 17'h12000: R2 feedback mask (x^17+x^14+1).
- `SEED`, default 41'h1_5A5A_C3C3_1: reset seed, packed as {R2,R1,R0} with R0 in the LSBs.
- `WARMUP`, default 64: number of steps discarded after reset or seed load (used only with `ALFSR_WARMUP_EN`).

Ports:
- `clk` input 1: clock. All logic is on the rising edge.
- `rst` input 1: **synchronous, active-high reset.**
- `en` input 1: step request. One LFSR step per cycle while high.
- `seed_load` input 1: single-cycle pulse that loads `seed_in`.
- `seed_in` input W0+W1+W2: seed, packed as {R2,R1,R0}.
- `RND_out` output 1: registered random bit.
- `RND_valid` output 1: high for exactly the cycles in which `RND_out` carries a new usable bit.
- `warming` output 1: high while the warm-up phase is discarding bits.

## Operation
LFSR step, for any register R of width W with mask T:
- Feedback `fb = ^(R & T)`.
- Next value `R_next = {R[W-2:0], fb}`.
- The register's output bit is `R[W-1]`.

One generator step, performed when `en=1` in state WARM or RUN:
- `c = R0[W0-1]`, taken before the update.
- R0 always steps.
- If `c=1`, R1 steps and R2 holds. If `c=0`, R2 steps and R1 holds.
- `RND_out <= R1_next[W1-1] ^ R2_next[W2-1]`.

Lockup guard (always built in):
- Any of R0, R1 or R2 that would load as all-zero, from `SEED` or `seed_in`, loads 1 instead.
- The slice checks are independent of each other.

FSM states:
- LOAD: one cycle. Loads the registers from the pending seed and clears the warm-up counter. Goes to WARM when the macro is defined, otherwise to RUN.
- WARM: steps on `en`. `RND_valid=0`, `warming=1`. A counter of width clog2(WARMUP+1) counts steps. After the WARMUP-th step it goes to RUN.
- RUN: steps on `en`. `RND_valid` is registered and equals the `en` of the step cycle.

Priority and boundary cases:
- `rst` has the highest priority. It enters LOAD with seed `SEED`.
- `seed_load` beats `en` in any state. It latches `seed_in` and enters LOAD. No step occurs and `RND_valid=0` in that cycle.
- `seed_load` during LOAD restarts LOAD with the new seed.
- `en=0` freezes all registers and the warm-up counter. `RND_out` holds its last value and `RND_valid=0`.
- WARMUP=0 with the macro defined: WARM is skipped and LOAD goes directly to RUN.
- Reset mid-warm-up or mid-run discards all state. No partial bit is output.

## Timing
Reset values:
- `RND_out=0`, `RND_valid=0`.
- `warming=0`.
- FSM = LOAD, with the registers loaded in the following cycle.

Latency:
- A step at edge k produces `RND_out`/`RND_valid` valid immediately after edge k.
- First possible valid bit, with `en` held high after `rst` deasserts:
  - Macro undefined: cycle 2 (1 LOAD cycle, then the first RUN step).
  - Macro defined: cycle WARMUP+2.
- Sustained throughput in RUN is 1 bit/cycle.

Period: R0 is maximal-length, 2^W0-1 = 2047 steps. R1 and R2 are maximal-length.

## Configuration
- `ALFSR_WARMUP_EN` defined: the WARM state, the warm-up counter and a live `warming` output are built.
- `ALFSR_WARMUP_EN` undefined: LOAD goes directly to RUN and `warming` is tied to 0. The `WARMUP` parameter is ignored.

## Structure
Shared package `alfsr_pkg` holds:
- The FSM state enum: LOAD, WARM, RUN.
- Default width, tap and seed constants.
- A `lfsr_next` function.

One sub-module, `lfsr_core` (parameters W, T), is instantiated three times. Its ports are `clk`, `rst_load`, `load_val`, `step` and `q`; it includes the zero-seed guard.

## Test plan
- Reset, `en=1`, macro undefined: `RND_valid` first rises at cycle 2 and stays high. With macro, WARMUP=64: first rise at cycle 66, and `warming` is high for cycles 2..65.
- `seed_in=0` via `seed_load`: every slice loads 1. After 2047 steps, R0 equals 1 again. `RND_valid` never sticks low in RUN.
- Toggle `en` 1/0 alternately for 200 cycles: the `RND_valid` pattern mirrors `en`. The concatenated valid bits match a reference model run with `en` held constantly high.
- `seed_load` asserted together with `en` mid-RUN: `RND_valid=0` in that cycle and the next. The stream then restarts identically to a fresh load of the same seed.
- Statistics: 4096 valid bits from `SEED` contain between 1948 and 2148 ones, and the downstream NIST test block asserts no error flag.
- `rst` pulsed mid-warm-up at step 30: the warm-up counter restarts, and the first valid bit again appears WARMUP+2 cycles after `rst` deasserts.
